// File: rtl/rca_lsq_pkg.sv
// Shared configuration for the RCA load/store queue: core widths, grid geometry,
// queue entry payload and controller state encoding.
package taiga_config;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned LOG2_MAX_IDS = 3;

    typedef logic [LOG2_MAX_IDS-1:0] id_t;
endpackage

package rca_config;
    import taiga_config::*;

    localparam int unsigned GRID_NUM_ROWS = 4;
    localparam int unsigned ROW_W         = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;

    typedef struct packed {
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
        logic [2:0]       fn3;
        logic             load;
        logic             store;
        logic [ROW_W-1:0] row;
    } lsq_entry_t;

    typedef enum logic [1:0] {
        LSQ_IDLE      = 2'd0,
        LSQ_ISSUE     = 2'd1,
        LSQ_WAIT_LOAD = 2'd2
    } lsq_state_t;
endpackage

// File: rtl/rca_lsq_if.sv
// LSU-facing request/response bundle of the RCA load/store queue.
interface rca_lsq_if;
    import taiga_config::*;

    logic [XLEN-1:0] lsu_rs1;
    logic [XLEN-1:0] lsu_rs2;
    logic [2:0]      lsu_fn3;
    logic            lsu_load;
    logic            lsu_store;
    logic            lsu_new_request;
    logic            rca_lsu_lock;
    id_t             lsu_id;
    logic            lsu_ready;
    logic            lsu_load_complete;
    logic [XLEN-1:0] lsu_load_data;
    id_t             rca_id;

    modport master (
        output lsu_rs1, lsu_rs2, lsu_fn3, lsu_load, lsu_store,
               lsu_new_request, rca_lsu_lock, lsu_id,
        input  lsu_ready, lsu_load_complete, lsu_load_data, rca_id
    );

    modport slave (
        input  lsu_rs1, lsu_rs2, lsu_fn3, lsu_load, lsu_store,
               lsu_new_request, rca_lsu_lock, lsu_id,
        output lsu_ready, lsu_load_complete, lsu_load_data, rca_id
    );
endinterface

// File: rtl/rca_lsq_multi_push_fifo.sv
// Circular queue accepting up to one entry per grid row per cycle (lower row first)
// and popping at most one entry per cycle from the head.
module rca_lsq_multi_push_fifo
    import rca_config::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [GRID_NUM_ROWS-1:0] push,
    input  lsq_entry_t               push_entry [GRID_NUM_ROWS],
    input  logic                     pop,
    output lsq_entry_t               head,
    output logic                     valid,
    output logic [CNT_W-1:0]         count,
    output logic                     fifo_full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    lsq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] slot [GRID_NUM_ROWS];
    logic [CNT_W-1:0] push_cnt;
    logic [CNT_W-1:0] next_count;
    logic             pop_ok;

    // Each requesting row lands after all lower requesting rows.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < GRID_NUM_ROWS; i++) begin
            slot[i]  = tail_ptr + PTR_W'(push_cnt);
            push_cnt = push_cnt + CNT_W'(push[i]);
        end
    end

    assign valid      = (count != '0);
    assign pop_ok     = pop & valid;
    assign next_count = count + push_cnt - CNT_W'(pop_ok);
    assign head       = mem[head_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
        end else begin
            head_ptr  <= head_ptr + PTR_W'(pop_ok);
            tail_ptr  <= tail_ptr + PTR_W'(push_cnt);
            count     <= next_count;
            fifo_full <= (next_count > CNT_W'(DEPTH - GRID_NUM_ROWS));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < GRID_NUM_ROWS; i++) begin
            if (push[i]) mem[slot[i]] <= push_entry[i];
        end
    end
endmodule

// File: rtl/rca_lsq.sv
// In-order load/store queue between the RCA grid rows and the LSU with a
// single outstanding load; load returns are routed back to the issuing row.
module rca_lsq
    import taiga_config::*;
    import rca_config::*;
#(
    parameter int unsigned RCA_LSQ_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          grid_addr [GRID_NUM_ROWS],
    input  logic [XLEN-1:0]          grid_data [GRID_NUM_ROWS],
    input  logic [2:0]               grid_fn3  [GRID_NUM_ROWS],
    input  logic [GRID_NUM_ROWS-1:0] grid_load,
    input  logic [GRID_NUM_ROWS-1:0] grid_store,
    input  logic [GRID_NUM_ROWS-1:0] grid_new_request,
    output logic                     fifo_full,
    output logic [GRID_NUM_ROWS-1:0] grid_load_complete,
    output logic [XLEN-1:0]          grid_load_data,
    rca_lsq_if.master                lsu
);
    localparam int unsigned CNT_W = $clog2(RCA_LSQ_DEPTH + 1);

    lsq_entry_t       push_entry [GRID_NUM_ROWS];
    lsq_entry_t       head;
    logic             head_valid;
    logic [CNT_W-1:0] count;
    lsq_state_t       state;
    lsq_state_t       state_next;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_next;
    logic [XLEN-1:0]  data_q;
    logic             issue;
    logic             complete;
    logic             any_push;

    assign any_push = |grid_new_request;

    always_comb begin
        for (int i = 0; i < GRID_NUM_ROWS; i++) begin
            push_entry[i] = '{addr:  grid_addr[i],
                              data:  grid_data[i],
                              fn3:   grid_fn3[i],
                              load:  grid_load[i],
                              store: grid_store[i],
                              row:   ROW_W'(i)};
        end
    end

    rca_lsq_multi_push_fifo #(.DEPTH(RCA_LSQ_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (grid_new_request),
        .push_entry (push_entry),
        .pop        (issue),
        .head       (head),
        .valid      (head_valid),
        .count      (count),
        .fifo_full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LSQ_IDLE;
            row_q  <= '0;
            data_q <= '0;
        end else begin
            state <= state_next;
            row_q <= row_next;
            if (complete) data_q <= lsu.lsu_load_data;
        end
    end

    // Controller: issue from the head, park on a load until it returns.
    always_comb begin
        state_next = state;
        row_next   = row_q;
        issue      = 1'b0;
        complete   = 1'b0;
        case (state)
            LSQ_IDLE: begin
                if (any_push) state_next = LSQ_ISSUE;
            end
            LSQ_ISSUE: begin
                issue = head_valid & lsu.lsu_ready & ~rst;
                if (issue && head.load) begin
                    state_next = LSQ_WAIT_LOAD;
                    row_next   = head.row;
                end else if ((count == CNT_W'(issue)) && !any_push) begin
                    state_next = LSQ_IDLE;
                end
            end
            LSQ_WAIT_LOAD: begin
                complete = lsu.lsu_load_complete & ~rst;
                if (complete) state_next = (head_valid || any_push) ? LSQ_ISSUE : LSQ_IDLE;
            end
            default: state_next = LSQ_IDLE;
        endcase
    end

    assign lsu.lsu_new_request = issue;
    assign lsu.lsu_rs1         = head.addr;
    assign lsu.lsu_rs2         = head.data;
    assign lsu.lsu_fn3         = head.fn3;
    assign lsu.lsu_load        = head.load;
    assign lsu.lsu_store       = head.store;
    assign lsu.lsu_id          = lsu.rca_id;
    assign lsu.rca_lsu_lock    = (state != LSQ_IDLE) | any_push;

    always_comb begin
        grid_load_complete = '0;
        if (complete) grid_load_complete[row_q] = 1'b1;
    end

    // Return value is visible in the completion cycle and held afterwards.
    assign grid_load_data = complete ? lsu.lsu_load_data : data_q;
endmodule

// File: tb/tb_rca_lsq.sv
// Randomized and directed bench for rca_lsq against a queue-level reference model.
module tb_rca_lsq;
    import taiga_config::*;
    import rca_config::*;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [XLEN-1:0] g_addr [ROWS];
    logic [XLEN-1:0] g_data [ROWS];
    logic [2:0]      g_fn3  [ROWS];
    logic [ROWS-1:0] g_load, g_store, g_req;
    logic            fifo_full;
    logic [ROWS-1:0] g_lc;
    logic [XLEN-1:0] g_ld;

    logic            ready, lc;
    logic [XLEN-1:0] ldata;
    id_t             rid;

    rca_lsq_if lsu_if();
    assign lsu_if.lsu_ready         = ready;
    assign lsu_if.lsu_load_complete = lc;
    assign lsu_if.lsu_load_data     = ldata;
    assign lsu_if.rca_id            = rid;

    rca_lsq #(.RCA_LSQ_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .grid_addr          (g_addr),
        .grid_data          (g_data),
        .grid_fn3           (g_fn3),
        .grid_load          (g_load),
        .grid_store         (g_store),
        .grid_new_request   (g_req),
        .fifo_full          (fifo_full),
        .grid_load_complete (g_lc),
        .grid_load_data     (g_ld),
        .lsu                (lsu_if)
    );

    // Reference model: queue of pending requests plus one outstanding-load slot.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  fn3;
        logic        ld;
        logic        st;
        int          row;
    } ment_t;

    ment_t       mq[$];
    bit          m_out;
    int          m_row;
    bit          m_full;
    logic [31:0] m_last;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit          exp_issue;
        logic [3:0]  exp_lc;
        logic [31:0] exp_ld;
        exp_issue = !rst && (mq.size() > 0) && !m_out && ready;
        exp_lc    = '0;
        exp_ld    = m_last;
        if (!rst && m_out && lc) begin
            exp_lc[m_row] = 1'b1;
            exp_ld        = ldata;
        end
        chk("lsu_new_request", 64'(lsu_if.lsu_new_request), 64'(exp_issue));
        if (exp_issue) begin
            chk("lsu_rs1",   64'(lsu_if.lsu_rs1),   64'(mq[0].addr));
            chk("lsu_rs2",   64'(lsu_if.lsu_rs2),   64'(mq[0].data));
            chk("lsu_fn3",   64'(lsu_if.lsu_fn3),   64'(mq[0].fn3));
            chk("lsu_load",  64'(lsu_if.lsu_load),  64'(mq[0].ld));
            chk("lsu_store", 64'(lsu_if.lsu_store), 64'(mq[0].st));
            chk("lsu_id",    64'(lsu_if.lsu_id),    64'(rid));
        end
        chk("rca_lsu_lock", 64'(lsu_if.rca_lsu_lock), 64'((mq.size() > 0) || m_out || (g_req != 0)));
        chk("fifo_full", 64'(fifo_full), 64'(m_full));
        chk("count", 64'(dut.u_fifo.count), 64'(mq.size()));
        chk("grid_load_complete", 64'(g_lc), 64'(exp_lc));
        chk("grid_load_data", 64'(g_ld), 64'(exp_ld));
    endtask

    task automatic model_update();
        ment_t e;
        bit    issue;
        if (rst) begin
            mq.delete();
            m_out  = 0;
            m_row  = 0;
            m_full = 0;
            m_last = '0;
            return;
        end
        issue = (mq.size() > 0) && !m_out && ready;
        if (m_out && lc) begin
            m_out  = 0;
            m_last = ldata;
        end
        if (issue) begin
            e = mq.pop_front();
            if (e.ld) begin
                m_out = 1;
                m_row = e.row;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            if (g_req[r]) begin
                e.addr = g_addr[r]; e.data = g_data[r]; e.fn3 = g_fn3[r];
                e.ld = g_load[r]; e.st = g_store[r]; e.row = r;
                mq.push_back(e);
            end
        end
        m_full = (DEPTH - mq.size()) < ROWS;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        g_req = '0; g_load = '0; g_store = '0; lc = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            g_addr[r] = '0; g_data[r] = '0; g_fn3[r] = '0;
        end
    endtask

    task automatic set_req(input int row, input bit is_load, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] fn3);
        g_req[row] = 1'b1; g_load[row] = is_load; g_store[row] = !is_load;
        g_addr[row] = addr; g_data[row] = data; g_fn3[row] = fn3;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; ldata = '0; rid = '0;
        clear_inputs();
        mq.delete(); m_out = 0; m_row = 0; m_full = 0; m_last = '0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_full", 64'(fifo_full), 64'h0);
        chk("reset_lock", 64'(lsu_if.rca_lsu_lock), 64'h0);
        chk("reset_count", 64'(dut.u_fifo.count), 64'h0);
        chk("reset_lc", 64'(g_lc), 64'h0);

        // Two stores from rows 0 and 2 issue in row order on consecutive cycles.
        set_req(0, 0, 32'h10, 32'h1111, 3'd2);
        set_req(2, 0, 32'h20, 32'h2222, 3'd2);
        ready = 1'b1;
        tick();
        clear_inputs(); #1;
        chk("st_issue0", 64'(lsu_if.lsu_new_request), 64'h1);
        chk("st_addr0", 64'(lsu_if.lsu_rs1), 64'h10);
        chk("st_data0", 64'(lsu_if.lsu_rs2), 64'h1111);
        tick(); #1;
        chk("st_issue1", 64'(lsu_if.lsu_new_request), 64'h1);
        chk("st_addr1", 64'(lsu_if.lsu_rs1), 64'h20);
        tick(); #1;
        chk("st_idle_lock", 64'(lsu_if.rca_lsu_lock), 64'h0);
        chk("st_idle_req", 64'(lsu_if.lsu_new_request), 64'h0);

        // Row 3 load returns three cycles after issue.
        set_req(3, 1, 32'h100, 32'h0, 3'd2);
        tick();
        clear_inputs(); #1;
        chk("ld_issue", 64'(lsu_if.lsu_new_request), 64'h1);
        chk("ld_is_load", 64'(lsu_if.lsu_load), 64'h1);
        chk("ld_addr", 64'(lsu_if.lsu_rs1), 64'h100);
        tick(); tick(); tick();
        lc = 1'b1; ldata = 32'hDEADBEEF; #1;
        chk("ld_strobe", 64'(g_lc), 64'h8);
        chk("ld_data", 64'(g_ld), 64'hDEADBEEF);
        tick();
        lc = 1'b0; #1;
        chk("ld_strobe_gone", 64'(g_lc), 64'h0);

        // Fill to capacity with the LSU stalled, then drain.
        ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < ROWS; r++)
                set_req(r, 0, 32'h200 + 32'(16 * k + 4 * r), 32'(4 * k + r), 3'd1);
            tick();
        end
        clear_inputs(); #1;
        chk("fill_count", 64'(dut.u_fifo.count), 64'h8);
        chk("fill_full", 64'(fifo_full), 64'h1);
        ready = 1'b1;
        tick(); #1;
        chk("pop1_full", 64'(fifo_full), 64'h1);
        repeat (4) tick();
        #1;
        chk("pop5_full", 64'(fifo_full), 64'h0);
        repeat (3) tick();
        #1;
        chk("drain_count", 64'(dut.u_fifo.count), 64'h0);

        // A store queued behind a load waits until after the load completes.
        set_req(1, 1, 32'h300, 32'h0, 3'd2);
        set_req(2, 0, 32'h304, 32'hCAFE, 3'd2);
        tick();
        clear_inputs();
        tick(); #1;
        chk("hold_w0", 64'(lsu_if.lsu_new_request), 64'h0);
        tick(); tick();
        lc = 1'b1; ldata = 32'h12345678; #1;
        chk("hold_at_cmpl", 64'(lsu_if.lsu_new_request), 64'h0);
        chk("hold_strobe", 64'(g_lc), 64'h2);
        tick();
        lc = 1'b0; #1;
        chk("after_issue", 64'(lsu_if.lsu_new_request), 64'h1);
        chk("after_addr", 64'(lsu_if.lsu_rs1), 64'h304);
        chk("after_store", 64'(lsu_if.lsu_store), 64'h1);
        tick(); tick();

        // Reset while a load is outstanding; the late response is ignored.
        set_req(0, 1, 32'h400, 32'h0, 3'd2);
        tick();
        clear_inputs();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; lc = 1'b1; ldata = 32'hBAD; #1;
        chk("late_strobe", 64'(g_lc), 64'h0);
        chk("late_lock", 64'(lsu_if.rca_lsu_lock), 64'h0);
        chk("late_count", 64'(dut.u_fifo.count), 64'h0);
        chk("late_data", 64'(g_ld), 64'h0);
        tick();
        lc = 1'b0;

        // Randomized traffic, well past several pointer wraps.
        repeat (600) begin
            clear_inputs();
            if (!m_full) begin
                for (int r = 0; r < ROWS; r++)
                    if ($urandom_range(2) == 0)
                        set_req(r, 1'($urandom_range(1)), $urandom, $urandom, 3'($urandom_range(7)));
            end
            ready = ($urandom_range(3) != 0);
            lc    = m_out ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            ldata = $urandom;
            rid   = id_t'($urandom);
            tick();
        end

        clear_inputs();
        ready = 1'b1;
        repeat (40) begin
            lc = m_out;
            ldata = $urandom;
            tick();
        end
        lc = 1'b0; #1;
        chk("end_count", 64'(dut.u_fifo.count), 64'h0);
        chk("end_lock", 64'(lsu_if.rca_lsu_lock), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
